// File: rtl/sig_debouncer.sv
// Level debouncer: two-flop synchronizer, four-state qualify FSM,
// registered level/busy outputs and a saturating rejected-change counter.
module sig_debouncer #(
  parameter int DEB_CYCLES = 4,
  parameter int GLITCH_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signal_in,
  output logic                signal,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    CHK_HIGH,
    ST_HIGH,
    CHK_LOW
  } state_t;

  logic                r_sync1;
  logic                r_sync2;
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_signal;
  logic                r_busy;
  logic [GLITCH_W-1:0] r_glitch;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_signal_nxt;
  logic                w_busy_nxt;
  logic                w_glitch_inc;
  logic                w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_state  <= ST_LOW;
      r_cnt    <= '0;
      r_signal <= 1'b0;
      r_busy   <= 1'b0;
      r_glitch <= '0;
    end else begin
      r_sync1  <= signal_in;
      r_sync2  <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_signal <= w_signal_nxt;
      r_busy   <= w_busy_nxt;
      if (w_glitch_inc && !(&r_glitch))
        r_glitch <= r_glitch + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_LOW:
        if (r_sync2) w_state_nxt = CHK_HIGH;
      CHK_HIGH:
        if (!r_sync2)        w_state_nxt = ST_LOW;
        else if (w_cnt_last) w_state_nxt = ST_HIGH;
      ST_HIGH:
        if (!r_sync2) w_state_nxt = CHK_LOW;
      CHK_LOW:
        if (r_sync2)         w_state_nxt = ST_HIGH;
        else if (w_cnt_last) w_state_nxt = ST_LOW;
    endcase
  end

  // cnt holds the number of agreeing samples seen so far in a check state
  always_comb begin
    w_cnt_nxt    = '0;
    w_glitch_inc = 1'b0;
    unique case (r_state)
      ST_LOW:
        if (r_sync2) w_cnt_nxt = CW'(1);
      CHK_HIGH:
        if (!r_sync2)         w_glitch_inc = 1'b1;
        else if (!w_cnt_last) w_cnt_nxt = r_cnt + CW'(1);
      ST_HIGH:
        if (!r_sync2) w_cnt_nxt = CW'(1);
      CHK_LOW:
        if (r_sync2)          w_glitch_inc = 1'b1;
        else if (!w_cnt_last) w_cnt_nxt = r_cnt + CW'(1);
    endcase
    w_signal_nxt = (w_state_nxt == ST_HIGH) ||
                   (w_state_nxt == CHK_LOW);
    w_busy_nxt   = (w_state_nxt == CHK_HIGH) ||
                   (w_state_nxt == CHK_LOW);
  end

  assign signal     = r_signal;
  assign busy       = r_busy;
  assign glitch_cnt = r_glitch;

endmodule

// File: doc/sig_debouncer.md
SIG_DEBOUNCER -- requirements
Module: sig_debouncer

Interface
REQ-001 The block SHALL have a parameter DEB_CYCLES, default 4, giving the consecutive synchronized samples needed to accept a level change; legal range is 2..255.
REQ-002 The block SHALL have a parameter GLITCH_W, default 8, giving the width of the glitch counter.
REQ-003 Port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-005 Port `signal_in`: input, 1 bit, raw asynchronous level (switch or pin).
REQ-006 Port `signal`: output, 1 bit, registered debounced level; this is the input of the downstream edge detector.
REQ-007 Port `busy`: output, 1 bit, registered; high while a candidate level change is being qualified.
REQ-008 Port `glitch_cnt`: output, GLITCH_W bits, registered count of rejected candidate changes.

Function
REQ-009 `signal_in` SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-010 The FSM SHALL have four states, all judged on sync2: ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW.
REQ-011 In ST_LOW, sync2=1 SHALL move the FSM to CHK_HIGH and load cnt=1; otherwise it stays in ST_LOW.
REQ-012 In CHK_HIGH, when sync2=1 and cnt<DEB_CYCLES-1, cnt SHALL increment.
REQ-013 In CHK_HIGH, when sync2=1 and cnt=DEB_CYCLES-1, the FSM SHALL move to ST_HIGH, set `signal`=1 and clear cnt to 0.
REQ-014 In CHK_HIGH, sync2=0 SHALL return the FSM to ST_LOW, clear cnt and increment glitch_cnt; `signal` stays 0.
REQ-015 ST_HIGH and CHK_LOW SHALL mirror REQ-011 to REQ-014 with the polarities inverted.
REQ-016 A level change SHALL be accepted only after exactly DEB_CYCLES consecutive equal sync2 samples; DEB_CYCLES-1 samples SHALL be rejected.
REQ-017 Latency: if `signal_in` is first sampled at its new level at edge j and then held, `signal` SHALL change after edge j+DEB_CYCLES+1 (j+5 at the default).
REQ-018 `busy` SHALL be 1 exactly when the FSM is in CHK_HIGH or CHK_LOW, as a registered state decode.
REQ-019 glitch_cnt SHALL saturate at 2^GLITCH_W-1 and never wrap.
REQ-020 `signal` SHALL change at most once per DEB_CYCLES clocks; it SHALL never produce a 1-cycle pulse.
REQ-021 cnt SHALL be ceil(log2(DEB_CYCLES)) bits wide.
REQ-022 Any sync2 value that is not a pending change SHALL leave cnt at 0 and `busy` at 0.

Reset
REQ-023 While `rst`=0, sync1, sync2, cnt, `signal`, `busy` and glitch_cnt SHALL be 0 and the FSM SHALL be in ST_LOW, independent of `clk`.
REQ-024 Reset asserted mid-qualification SHALL abort it with no glitch_cnt increment.
REQ-025 After `rst` deasserts, the first FSM decision SHALL use sync2, which is valid no earlier than the second rising edge after release.
REQ-026 If `signal_in`=1 at reset release, `signal` SHALL rise DEB_CYCLES+1 edges after the first sampling edge.

Verification
REQ-027 Reset held, `signal_in` toggling -> `signal`=0, `busy`=0, glitch_cnt=0 throughout.
REQ-028 DEB_CYCLES=4; `signal_in` rises and is held 20 cycles -> `busy` high for 3 cycles, `signal` rises after edge j+5, glitch_cnt stays 0.
REQ-029 `signal_in` high for 3 sampled cycles, then low -> `signal` stays 0, glitch_cnt=1, `busy` returns to 0.
REQ-030 Bounce burst of 1, 2, 1 high cycles, then held high -> glitch_cnt=3, `signal` rises exactly once, and the downstream pedge fires once.
REQ-031 GLITCH_W=2 with 5 rejected glitches -> glitch_cnt saturates at 3.
REQ-032 `rst` pulsed low while in CHK_HIGH with cnt=2 -> all outputs 0 immediately, no increment, and normal qualification resumes after release.
